mux_select_arbiter: RTL and testbench

- Round-robin arbiter for a shared 4:1 selection path.
- Four requesters compete for the path. The block grants one at a time and drives the registered 2-bit select that steers the shared 4:1 mux.
- Bounds each grant by a hold limit so no requester can starve the others.
- Sits between the requesting units and the mux select input in the ALU/datapath.

---
 rtl/mux_select_arbiter.sv | 105 ++++++++++
 tb/tb_mux_select_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux, with a per-owner hold limit
// so that a continuously requesting unit cannot starve the others.
module mux_select_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [0:0] stIdle  = 1'b0;
    localparam logic [0:0] stGrant = 1'b1;

    localparam logic [CNT_W-1:0] holdMax = CNT_W'(MAX_HOLD);

    logic [0:0]       stateQ, stateD;
    logic [1:0]       lastOwnerQ, lastOwnerD;
    logic [3:0]       gntQ, gntD;
    logic [1:0]       selQ, selD;
    logic [CNT_W-1:0] holdQ, holdD;

    logic [3:0] candReq;
    logic       winValid;
    logic [1:0] winIdx;
    logic [1:0] probe;
    logic       ownerReq;
    logic       holdLimit;

    // While granted, the owner is excluded so a preemption always picks someone else.
    always_comb begin
        candReq = req;
        if (stateQ == stGrant) begin
            candReq = req & ~(4'b0001 << lastOwnerQ);
        end
    end

    // Scan from farthest to nearest so the nearest candidate after lastOwner wins.
    always_comb begin
        winValid = 1'b0;
        winIdx   = lastOwnerQ;
        probe    = lastOwnerQ;
        for (int k = 4; k >= 1; k--) begin
            probe = lastOwnerQ + 2'(k);
            if (candReq[probe]) begin
                winValid = 1'b1;
                winIdx   = probe;
            end
        end
    end

    assign ownerReq  = req[lastOwnerQ];
    assign holdLimit = (holdQ >= holdMax);

    always_comb begin
        stateD     = stateQ;
        lastOwnerD = lastOwnerQ;
        gntD       = gntQ;
        selD       = selQ;
        holdD      = holdQ;
        if ((stateQ == stGrant) && ownerReq && (!holdLimit || !winValid)) begin
            // Owner keeps the path; counter saturates once the limit is reached.
            if (!holdLimit) begin
                holdD = holdQ + CNT_W'(1);
            end
        end else if (winValid) begin
            stateD     = stGrant;
            lastOwnerD = winIdx;
            gntD       = 4'b0001 << winIdx;
            selD       = winIdx;
            holdD      = CNT_W'(1);
        end else begin
            // sel deliberately keeps its last value when the path goes idle.
            stateD = stIdle;
            gntD   = 4'b0000;
            holdD  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ     <= stIdle;
            lastOwnerQ <= 2'd3;
            gntQ       <= 4'b0000;
            selQ       <= 2'b00;
            holdQ      <= '0;
        end else begin
            stateQ     <= stateD;
            lastOwnerQ <= lastOwnerD;
            gntQ       <= gntD;
            selQ       <= selD;
            holdQ      <= holdD;
        end
    end

    assign gnt      = gntQ;
    assign sel      = selQ;
    assign busy     = (stateQ == stGrant);
    assign hold_cnt = holdQ;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Bench for mux_select_arbiter: two instances (hold limits 4 and 1) share stimulus
// and are compared every cycle against a round-robin model, plus literal checks.
module tb_mux_select_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;

    logic [3:0] gnt4, gnt1;
    logic [1:0] sel4, sel1;
    logic       busy4, busy1;
    logic [3:0] hc4, hc1;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    mux_select_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .gnt(gnt4), .sel(sel4), .busy(busy4), .hold_cnt(hc4)
    );

    mux_select_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .gnt(gnt1), .sel(sel1), .busy(busy1), .hold_cnt(hc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // owner = -1 means idle
    typedef struct {
        int owner;
        int last;
        int hold;
        int sel;
    } mstate_t;

    mstate_t m4, m1;

    function automatic mstate_t modelReset();
        mstate_t s;
        s.owner = -1;
        s.last  = 3;
        s.hold  = 0;
        s.sel   = 0;
        return s;
    endfunction

    function automatic mstate_t modelNext(input mstate_t s, input logic [3:0] r, input int maxHold);
        mstate_t n;
        logic [3:0] others;
        bit found;
        int win;
        n = s;
        others = r;
        if (s.owner >= 0) others[s.owner] = 1'b0;
        if (s.owner >= 0 && r[s.owner] && (s.hold < maxHold || others == 4'b0)) begin
            n.hold = (s.hold < maxHold) ? s.hold + 1 : maxHold;
        end else begin
            found = 1'b0;
            win = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && others[(s.last + k) % 4]) begin
                    found = 1'b1;
                    win = (s.last + k) % 4;
                end
            end
            if (found) begin
                n.owner = win;
                n.last  = win;
                n.sel   = win;
                n.hold  = 1;
            end else begin
                n.owner = -1;
                n.hold  = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m4 <= modelReset();
            m1 <= modelReset();
        end else begin
            m4 <= modelNext(m4, req, 4);
            m1 <= modelNext(m1, req, 1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareDut(input string tag, input mstate_t m, input logic [3:0] g,
                              input logic [1:0] s, input logic b, input logic [3:0] h);
        int expGnt;
        expGnt = (m.owner >= 0) ? (1 << m.owner) : 0;
        check({tag, ".gnt"}, int'(g), expGnt);
        check({tag, ".sel"}, int'(s), m.sel);
        check({tag, ".busy"}, int'(b), (m.owner >= 0) ? 1 : 0);
        check({tag, ".hold_cnt"}, int'(h), m.hold);
        check({tag, ".onehot0"}, ($countones(g) <= 1) ? 1 : 0, 1);
        check({tag, ".busy_eq_or"}, int'(b), int'(|g));
    endtask

    always @(negedge clk) begin
        if (checkEn && reset_n) begin
            compareDut("mh4", m4, gnt4, sel4, busy4, hc4);
            compareDut("mh1", m1, gnt1, sel1, busy1, hc1);
        end
    end

    task automatic resetPulse();
        @(negedge clk);
        #2 reset_n = 1'b0;
        req = 4'b0000;
        #2 reset_n = 1'b1;
    endtask

    task automatic checkCleared(input string tag);
        check({tag, ".gnt4"}, int'(gnt4), 0);
        check({tag, ".busy4"}, int'(busy4), 0);
        check({tag, ".hold4"}, int'(hc4), 0);
        check({tag, ".gnt1"}, int'(gnt1), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        req = 4'b0000;
        #1 checkCleared("por");
        check("por.sel4", int'(sel4), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        checkEn = 1'b1;

        // Single requester, then release.
        resetPulse();
        @(negedge clk) req = 4'b0001;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t1.gnt", int'(gnt4), 1);
            check("t1.sel", int'(sel4), 0);
            check("t1.busy", int'(busy4), 1);
            check("t1.hold", int'(hc4), i);
        end
        req = 4'b0000;
        @(negedge clk);
        check("t1.rel_gnt", int'(gnt4), 0);
        check("t1.rel_busy", int'(busy4), 0);

        // All requesting: rotate every 4 cycles (every cycle for limit 1).
        resetPulse();
        @(negedge clk) req = 4'b1111;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("t2.sel4", int'(sel4), ((i - 1) / 4) % 4);
            check("t2.hold4", int'(hc4), ((i - 1) % 4) + 1);
            check("t2.sel1", int'(sel1), (i - 1) % 4);
        end

        // Lone requester saturates the counter without preemption.
        resetPulse();
        @(negedge clk) req = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("t3.gnt4", int'(gnt4), 4);
            check("t3.hold4", int'(hc4), (i < 4) ? i : 4);
            check("t3.hold1", int'(hc1), 1);
        end

        // Owner 1 releases while 0 and 3 arrive: 3 follows 1, no bubble.
        resetPulse();
        @(negedge clk) req = 4'b0010;
        repeat (2) @(negedge clk);
        check("t4.pre_gnt", int'(gnt4), 2);
        req = 4'b1001;
        @(negedge clk);
        check("t4.gnt", int'(gnt4), 8);
        check("t4.sel", int'(sel4), 3);
        check("t4.busy", int'(busy4), 1);

        // Asynchronous reset mid-grant, then pointer restarts at requester 0 side.
        resetPulse();
        @(negedge clk) req = 4'b0100;
        repeat (3) @(negedge clk);
        check("t5.pre_gnt", int'(gnt4), 4);
        #2 reset_n = 1'b0;
        #1 checkCleared("t5.async");
        req = 4'b1010;
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("t5.first_gnt", int'(gnt4), 2);

        // Limit 1 alternates between two requesters every cycle.
        resetPulse();
        @(negedge clk) req = 4'b0101;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("t6.gnt1", int'(gnt1), (i % 2 == 1) ? 1 : 4);
        end

        // Random traffic with occasional asynchronous resets.
        resetPulse();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
            if ($urandom_range(299) == 0) begin
                #2 reset_n = 1'b0;
                #1 checkCleared("rnd.async");
                #1 reset_n = 1'b1;
            end
        end

        @(negedge clk);
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
